// File: rtl/hc4511_scan_driver.sv
// Time-multiplexed scan driver for one shared HC4511 decoder across DIGITS digits.
// Each slot blanks, latches the BCD code, then lights its digit; frames swap only at end of scan.
`timescale 1ns/1ps
module hc4511_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  LOAD_VALID,
    output logic                  LOAD_READY,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic                  LZB_EN,
    input  logic                  TEST_N,
    output logic [3:0]            A,
    output logic                  LE,
    output logic                  BI_N,
    output logic                  LT_N,
    output logic [DIGITS-1:0]     DIG,
    output logic                  FRAME_DONE
);
    localparam int CW = $clog2(PRESCALE);
    localparam int SW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_LATCH = CW'(BLANK_CYC);

    typedef enum logic [1:0] {PH_BLANK, PH_LATCH, PH_SHOW} phase_e;

    function automatic logic [DIGITS-1:0] lzb_mask(input logic [4*DIGITS-1:0] d, input logic en);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (d[4*i +: 4] == 4'd0);
            m[i]       = en & zero_above;
        end
        return m;
    endfunction

    logic                run_q, run_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic                pend_q, pend_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic                ready_q, ready_d;
    logic [3:0]          a_q, a_d;
    logic                le_q, le_d;
    logic                bi_n_q, bi_n_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                fd_q, fd_d;
    logic                lt_n_q, lt_n_d;
    logic                commit;
    phase_e              phase_d;

    // run_q holds the counter at slot 0, cycle 0 for the first edge after reset release
    always_comb begin
        run_d       = 1'b1;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        disp_d      = disp_q;
        pend_data_d = pend_data_q;
        pend_d      = pend_q;
        mask_d      = mask_q;
        ready_d     = ready_q;
        a_d         = a_q;
        le_d        = le_q;
        bi_n_d      = bi_n_q;
        dig_d       = dig_q;
        lt_n_d      = TEST_N;
        commit      = run_q && (cnt_q == CNT_LAST) && (slot_q == SLOT_LAST);

        if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Commit before accepting: a transfer can only happen with nothing pending
        if (commit) begin
            if (pend_q) begin
                disp_d  = pend_data_q;
                pend_d  = 1'b0;
                ready_d = 1'b1;
            end
            mask_d = lzb_mask(disp_d, LZB_EN);
        end
        if (LOAD_VALID && ready_q) begin
            pend_data_d = DATA;
            pend_d      = 1'b1;
            ready_d     = 1'b0;
        end

        if (cnt_d < CNT_LATCH)       phase_d = PH_BLANK;
        else if (cnt_d == CNT_LATCH) phase_d = PH_LATCH;
        else                         phase_d = PH_SHOW;

        // Outputs are registered, so they are derived from next-state slot and count
        case (phase_d)
            PH_BLANK: begin
                a_d    = disp_d[4*int'(slot_d) +: 4];
                le_d   = 1'b0;
                bi_n_d = 1'b0;
                dig_d  = '0;
            end
            PH_LATCH: begin
                le_d   = 1'b1;
                bi_n_d = 1'b0;
                dig_d  = '0;
            end
            default: begin
                le_d = 1'b1;
                if (mask_d[slot_d]) begin
                    bi_n_d = 1'b0;
                    dig_d  = '0;
                end else begin
                    bi_n_d = 1'b1;
                    dig_d  = DIGITS'(1) << slot_d;
                end
            end
        endcase
        fd_d = (cnt_d == CNT_LAST) && (slot_d == SLOT_LAST);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_q       <= 1'b0;
            cnt_q       <= '0;
            slot_q      <= '0;
            disp_q      <= '0;
            pend_data_q <= '0;
            pend_q      <= 1'b0;
            mask_q      <= '0;
            ready_q     <= 1'b1;
            a_q         <= 4'd0;
            le_q        <= 1'b1;
            bi_n_q      <= 1'b0;
            dig_q       <= '0;
            fd_q        <= 1'b0;
            lt_n_q      <= 1'b1;
        end else begin
            run_q       <= run_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            disp_q      <= disp_d;
            pend_data_q <= pend_data_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            ready_q     <= ready_d;
            a_q         <= a_d;
            le_q        <= le_d;
            bi_n_q      <= bi_n_d;
            dig_q       <= dig_d;
            fd_q        <= fd_d;
            lt_n_q      <= lt_n_d;
        end
    end

    assign LOAD_READY = ready_q;
    assign A          = a_q;
    assign LE         = le_q;
    assign BI_N       = bi_n_q;
    assign LT_N       = lt_n_q;
    assign DIG        = dig_q;
    assign FRAME_DONE = fd_q;
endmodule

// File: tb/tb_hc4511_scan_driver.sv
// Directed bench for hc4511_scan_driver with DIGITS=4, PRESCALE=8, BLANK_CYC=2 (32-cycle frames).
`timescale 1ns/1ps
module tb_hc4511_scan_driver;
    localparam int DIGITS    = 4;
    localparam int PRESCALE  = 8;
    localparam int BLANK_CYC = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        LOAD_VALID = 1'b0;
    logic        LOAD_READY;
    logic [15:0] DATA = 16'h0;
    logic        LZB_EN = 1'b0;
    logic        TEST_N = 1'b1;
    logic [3:0]  A;
    logic        LE, BI_N, LT_N, FRAME_DONE;
    logic [3:0]  DIG;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [15:0] rnd_masks [4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};

    hc4511_scan_driver #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
        .DATA(DATA), .LZB_EN(LZB_EN), .TEST_N(TEST_N), .A(A), .LE(LE), .BI_N(BI_N),
        .LT_N(LT_N), .DIG(DIG), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, required finish before 1ms");
        $fatal(1);
    end

    // Highest nonzero digit h; every digit above h is blanked when enabled
    function automatic logic [3:0] lzb_exp(input logic [15:0] d, input logic en);
        int h;
        logic [3:0] m;
        h = 0;
        for (int i = 0; i < 4; i++) if (d[4*i +: 4] != 4'd0) h = i;
        for (int i = 0; i < 4; i++) m[i] = en && (i > h);
        return m;
    endfunction

    // Expected {A, LE, BI_N, DIG} at frame-relative cycle c
    function automatic logic [9:0] scan_exp(input logic [15:0] d, input logic [3:0] m, input int c);
        int k, s;
        logic show;
        k = c % 8;
        s = (c / 8) % 4;
        show = (k > BLANK_CYC) && !m[s];
        return {d[4*s +: 4], (k >= BLANK_CYC), show, show ? (4'b0001 << s) : 4'b0000};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        LOAD_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        cyc = -1;
        step();
    endtask

    task automatic test_reset();
        logic [9:0] e;
        RST_N = 1'b1;
        #1;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({A, LE, BI_N, LT_N, DIG, FRAME_DONE, LOAD_READY} !== 13'b0000_1_0_1_0000_0_1) begin
            errors++;
            $display("FAIL reset_initial got %b required %b",
                     {A, LE, BI_N, LT_N, DIG, FRAME_DONE, LOAD_READY}, 13'b0000_1_0_1_0000_0_1);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        cyc = -1;
        step();
        LOAD_VALID = 1'b1;
        DATA = 16'h1234;
        repeat (8) begin
            e = scan_exp(16'h0, 4'h0, cyc);
            checks++;
            if ({A, LE, BI_N, DIG} !== e) begin
                errors++;
                $display("FAIL reset_first_slot cyc=%0d got %b required %b", cyc, {A, LE, BI_N, DIG}, e);
            end
            step();
            if (cyc == 1) LOAD_VALID = 1'b0;
        end
        while (cyc < 45) begin
            step();
            if (cyc == 33) begin LOAD_VALID = 1'b1; DATA = 16'h9999; end
            if (cyc == 34) LOAD_VALID = 1'b0;
            if (cyc == 40) TEST_N = 1'b0;
        end
        checks++;
        if ({A, DIG, LOAD_READY, LT_N} !== {4'h3, 4'b0010, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_pre_show got %b required %b", {A, DIG, LOAD_READY, LT_N},
                     {4'h3, 4'b0010, 1'b0, 1'b0});
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({A, LE, BI_N, LT_N, DIG, FRAME_DONE, LOAD_READY} !== 13'b0000_1_0_1_0000_0_1) begin
            errors++;
            $display("FAIL reset_async_midshow got %b required %b",
                     {A, LE, BI_N, LT_N, DIG, FRAME_DONE, LOAD_READY}, 13'b0000_1_0_1_0000_0_1);
        end
        TEST_N = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        cyc = -1;
        step();
        repeat (64) begin
            e = scan_exp(16'h0, 4'h0, cyc);
            checks++;
            if ({A, LE, BI_N, DIG, LOAD_READY, FRAME_DONE} !== {e, 1'b1, (cyc % 32 == 31)}) begin
                errors++;
                $display("FAIL reset_restart cyc=%0d got %b required %b", cyc,
                         {A, LE, BI_N, DIG, LOAD_READY, FRAME_DONE}, {e, 1'b1, (cyc % 32 == 31)});
            end
            step();
        end
    endtask

    task automatic test_load();
        logic [9:0]  e;
        logic [15:0] d;
        do_reset();
        checks++;
        if (LOAD_READY !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_idle got %b required 1", LOAD_READY);
        end
        LOAD_VALID = 1'b1;
        DATA = 16'h1234;
        step();
        LOAD_VALID = 1'b0;
        while (cyc < 64) begin
            d = (cyc < 32) ? 16'h0000 : 16'h1234;
            e = scan_exp(d, 4'h0, cyc);
            checks++;
            if ({A, LE, BI_N, DIG} !== e) begin
                errors++;
                $display("FAIL load_scan cyc=%0d got %b required %b", cyc, {A, LE, BI_N, DIG}, e);
            end
            checks++;
            if ({FRAME_DONE, LOAD_READY} !== {(cyc % 32 == 31), (cyc >= 32)}) begin
                errors++;
                $display("FAIL load_done_ready cyc=%0d got %b required %b", cyc,
                         {FRAME_DONE, LOAD_READY}, {(cyc % 32 == 31), (cyc >= 32)});
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  e;
        logic [15:0] d;
        logic        er;
        do_reset();
        LOAD_VALID = 1'b1;
        DATA = 16'h1234;
        step();
        DATA = 16'h5678;
        while (cyc < 96) begin
            er = (cyc == 32) || (cyc >= 64);
            checks++;
            if (LOAD_READY !== er) begin
                errors++;
                $display("FAIL b2b_ready cyc=%0d got %b required %b", cyc, LOAD_READY, er);
            end
            d = (cyc < 32) ? 16'h0000 : (cyc < 64) ? 16'h1234 : 16'h5678;
            e = scan_exp(d, 4'h0, cyc);
            checks++;
            if ({A, LE, BI_N, DIG} !== e) begin
                errors++;
                $display("FAIL b2b_scan cyc=%0d got %b required %b", cyc, {A, LE, BI_N, DIG}, e);
            end
            step();
            if (cyc == 33) LOAD_VALID = 1'b0;
        end
    endtask

    task automatic test_lzb();
        logic [9:0]  e;
        logic [15:0] d;
        do_reset();
        LZB_EN = 1'b1;
        LOAD_VALID = 1'b1;
        DATA = 16'h0050;
        step();
        LOAD_VALID = 1'b0;
        while (cyc < 96) begin
            if (cyc >= 32) begin
                d = (cyc < 64) ? 16'h0050 : 16'h0000;
                e = scan_exp(d, lzb_exp(d, 1'b1), cyc);
                checks++;
                if ({A, LE, BI_N, DIG} !== e) begin
                    errors++;
                    $display("FAIL lzb_scan cyc=%0d got %b required %b", cyc, {A, LE, BI_N, DIG}, e);
                end
            end
            if (cyc == 32) begin LOAD_VALID = 1'b1; DATA = 16'h0000; end
            step();
            if (cyc == 33) LOAD_VALID = 1'b0;
        end
        LZB_EN = 1'b0;
    endtask

    task automatic test_latch_safety();
        logic [15:0] dat [4];
        logic        en  [4];
        logic [3:0]  a_prev;
        logic [9:0]  e;
        int          f;
        do_reset();
        a_prev = A;
        while (cyc < 160) begin
            f = cyc / 32;
            if (LE === 1'b1) begin
                checks++;
                if (A !== a_prev) begin
                    errors++;
                    $display("FAIL latch_a_stable cyc=%0d got %h required %h", cyc, A, a_prev);
                end
            end
            if (DIG !== 4'b0000) begin
                checks++;
                if (BI_N !== 1'b1) begin
                    errors++;
                    $display("FAIL latch_dig_blank cyc=%0d got BI_N=%b required 1", cyc, BI_N);
                end
            end
            if (f >= 1) begin
                e = scan_exp(dat[f-1], lzb_exp(dat[f-1], en[f-1]), cyc);
                checks++;
                if ({A, LE, BI_N, DIG} !== e) begin
                    errors++;
                    $display("FAIL latch_scan cyc=%0d got %b required %b", cyc, {A, LE, BI_N, DIG}, e);
                end
            end
            if ((cyc % 32 == 0) && (f < 4)) begin
                dat[f] = 16'($urandom) & rnd_masks[$urandom_range(0, 3)];
                en[f]  = 1'($urandom_range(0, 1));
                LOAD_VALID = 1'b1;
                DATA = dat[f];
                LZB_EN = en[f];
            end
            a_prev = A;
            step();
            if (cyc % 32 == 1) LOAD_VALID = 1'b0;
        end
        LZB_EN = 1'b0;
    endtask

    task automatic test_lamp();
        logic [9:0] e;
        logic       elt;
        do_reset();
        while (cyc < 32) begin
            elt = !((cyc >= 5) && (cyc <= 20));
            checks++;
            if (LT_N !== elt) begin
                errors++;
                $display("FAIL lamp_lt cyc=%0d got %b required %b", cyc, LT_N, elt);
            end
            e = scan_exp(16'h0, 4'h0, cyc);
            checks++;
            if ({A, LE, BI_N, DIG, FRAME_DONE} !== {e, (cyc == 31)}) begin
                errors++;
                $display("FAIL lamp_scan cyc=%0d got %b required %b", cyc,
                         {A, LE, BI_N, DIG, FRAME_DONE}, {e, (cyc == 31)});
            end
            if (cyc == 4)  TEST_N = 1'b0;
            if (cyc == 20) TEST_N = 1'b1;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_lzb();
        test_latch_safety();
        test_lamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hc4511_scan_driver.md
Name: hc4511_scan_driver

Overview:
- Upstream feeder for the HC4511 BCD latch/decoder. It drives one shared decoder across DIGITS common-cathode digits in time-multiplexed fashion.
- Holds a frame of BCD digits loaded through a valid/ready handshake. Per digit slot it sequences A, LE, BI_N and a one-hot digit enable with a blanking guard, so no segment ghosting reaches the display.
- Optional leading-zero blanking; lamp-test request passed through as LT_N.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant.
- PRESCALE, 1000, clock cycles per digit slot; must be >= BLANK_CYC+2.
- BLANK_CYC, 4, guard cycles per slot with BI_N low and all DIG off (>=1).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- LOAD_VALID  in  1  new frame offered on DATA.
- LOAD_READY  out  1  block can accept a frame.
- DATA  in  4*DIGITS  BCD frame, digit i at DATA[4i+3:4i].
- LZB_EN  in  1  leading-zero blanking enable.
- TEST_N  in  1  lamp-test request, active low.
- A  out  4  BCD code to HC4511 A[3:0].
- LE  out  1  HC4511 latch enable: 0 = transparent, 1 = hold.
- BI_N  out  1  HC4511 blanking, active low.
- LT_N  out  1  HC4511 lamp test, active low.
- DIG  out  DIGITS  one-hot digit-common enable, active high.
- FRAME_DONE  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Interface: one clock, CLK; reset RST_N is asynchronous, active-low. All outputs are registered.
- Reset values (immediate on RST_N low, no clock needed):
  - A=0, LE=1, BI_N=0, LT_N=1, DIG=0, FRAME_DONE=0, LOAD_READY=1.
  - Display register=0, pending register/flag cleared, slot=0, cnt=0.
- Slot counter cnt runs 0..PRESCALE-1, then wraps. Slot index wraps DIGITS-1 -> 0. A slot cycle k is the cycle in which cnt==k, and outputs reflect k in that cycle.
- Per-slot state machine:
  - BLANK, k < BLANK_CYC: BI_N=0, DIG=0, LE=0, A=digit[slot].
  - LATCH, k == BLANK_CYC: LE=1, BI_N=0, DIG=0, A unchanged.
  - SHOW, k > BLANK_CYC: LE=1, DIG=onehot(slot). BI_N=1 unless the slot is blanked by LZB; then BI_N=0 and DIG=0.
- A changes only in BLANK, never while LE=1, so the latch never captures a transition.
- Handshake:
  - Transfer occurs when LOAD_VALID && LOAD_READY. DATA is captured into the pending register, the pending flag is set, and LOAD_READY=0 from the next cycle.
  - LOAD_VALID while LOAD_READY=0 is ignored. The producer must hold it; no data is lost or overwritten.
- Commit point is k==PRESCALE-1 of slot DIGITS-1:
  - FRAME_DONE=1 for that one cycle.
  - If pending is set, the display register takes the pending value on that edge and the pending flag clears. LOAD_READY=1 from the next cycle.
  - The new frame first appears at slot 0, cycle 0. A frame is never torn mid-scan.
- LZB is evaluated at commit from the committed data, and the LZB_EN value sampled on the same edge:
  - Digit i (i>=1) is blanked iff LZB_EN=1 and digits DIGITS-1..i are all 0.
  - Digit 0 is never blanked.
- LT_N = TEST_N delayed by one flop. Scanning continues during lamp test.
- BCD codes >9 pass through unmodified; the decoder blanks them.
- Reset mid-operation aborts any slot and discards pending data. After RST_N rises, the scan restarts at slot 0, cycle 0, showing zeros.

Test Plan:
(all with DIGITS=4, PRESCALE=8, BLANK_CYC=2)
- Reset: RST_N low mid-SHOW -> outputs go to A=0, LE=1, BI_N=0, DIG=0, LOAD_READY=1 within the same cycle, no clock needed. After release: cycles 0-1 LE=0/BI_N=0, cycle 2 LE=1, cycles 3-7 DIG=0001/BI_N=1/A=0.
- Load: DATA=0x1234 accepted in frame 0 -> LOAD_READY=0 next cycle; frame 0 shows all 0. Then:
  - FRAME_DONE pulses at cycle 31.
  - Frame 1 slots 0..3 drive A=4,3,2,1 with DIG=0001,0010,0100,1000.
  - LOAD_READY returns to 1 at cycle 32.
- Backpressure: LOAD_VALID held with DATA=0x5678 while pending -> not taken until LOAD_READY=1. Frame 1 shows 0x1234, frame 2 shows 0x5678.
- LZB: DATA=0x0050, LZB_EN=1 -> slots 3,2 keep BI_N=0, DIG=0 through SHOW; slot 1 A=5, BI_N=1; slot 0 A=0, BI_N=1. With DATA=0x0000, only slot 0 lit.
- Latch safety: over 4 frames of random data, A never changes while LE=1, and DIG!=0 only when BI_N=1.
- Lamp test: TEST_N=0 -> LT_N=0 one cycle later; scan timing unchanged; TEST_N=1 -> LT_N=1 one cycle later.
